// File: rtl/csi2_pkg.sv
// Purpose: shared CSI-2 constants, parser state encoding and header ECC helper.
// Latency: n/a (declarations and a pure combinational function).
// Backpressure: n/a.
package csi2_pkg;

    localparam logic [5:0] DT_FS       = 6'h00;
    localparam logic [5:0] DT_FE       = 6'h01;
    localparam logic [5:0] DT_RAW10    = 6'h2B;
    localparam logic [5:0] DT_LONG_MIN = 6'h10;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAYLOAD,
        CRC,
        SKIP
    } state_e;

    // Header ECC over {WC MSB, WC LSB, DI}; each mask selects the data bits
    // feeding one parity bit. The two top ECC bits are always zero.
    function automatic logic [7:0] csi2_ecc(input logic [23:0] hdr);
        logic [7:0] ecc;
        ecc[0] = ^(hdr & 24'hF12CB7);
        ecc[1] = ^(hdr & 24'hF2555B);
        ecc[2] = ^(hdr & 24'h749A6D);
        ecc[3] = ^(hdr & 24'hB8E38E);
        ecc[4] = ^(hdr & 24'hDF03F0);
        ecc[5] = ^(hdr & 24'hEFFC00);
        ecc[7:6] = 2'b00;
        return ecc;
    endfunction

endpackage

// File: rtl/csi2_rx_packet_parser_if.sv
// Purpose: HS byte stream from the D-PHY receive path into the packet parser.
// Latency: n/a (wires only).
// Backpressure: none; the PHY cannot be stalled, bytes arrive every cycle of a burst.
interface csi2_rx_packet_parser_if;
    logic       sot;
    logic       byte_valid;
    logic [7:0] byte_data;

    modport master (output sot, output byte_valid, output byte_data);
    modport slave  (input  sot, input  byte_valid, input  byte_data);
endinterface

// File: rtl/csi2_crc16.sv
// Purpose: byte-wide CRC-16 (x^16+x^12+x^5+1, LSB first, init 0xFFFF) accumulator.
// Latency: crc_o reflects all bytes enabled up to the previous clock edge.
// Backpressure: none; en_i simply gates the update.
module csi2_crc16 (
    input  logic        hf_clk90,
    input  logic        reset_n_byte,
    input  logic        clear_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    // Fold one byte into the running CRC, least significant bit first.
    always_comb begin
        crc_d = crc_q;
        for (int i = 0; i < 8; i++) begin
            if (crc_d[0] ^ data_i[i]) crc_d = {1'b0, crc_d[15:1]} ^ 16'h8408;
            else                      crc_d = {1'b0, crc_d[15:1]};
        end
    end

    // Clear restarts the accumulation for a new packet and wins over enable.
    always_ff @(posedge hf_clk90 or negedge reset_n_byte) begin
        if (!reset_n_byte)  crc_q <= 16'hFFFF;
        else if (clear_i)   crc_q <= 16'hFFFF;
        else if (en_i)      crc_q <= crc_d;
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/csi2_rx_packet_parser.sv
// Purpose: parse CSI-2 packets, check ECC/CRC, regenerate FV/LV and forward payload.
// Latency: all outputs registered; a byte at cycle N produces its effect at N+1.
// Backpressure: none; the byte stream is never stalled, errors abandon the packet.
module csi2_rx_packet_parser
    import csi2_pkg::*;
#(
    parameter logic [15:0] MAX_WC    = 16'd320,
    parameter logic [1:0]  ACCEPT_VC = 2'b00,
    parameter logic [5:0]  EXPECT_DT = 6'h2B
) (
    input  logic        hf_clk90,
    input  logic        reset_n_byte,
    csi2_rx_packet_parser_if.slave byte_if,
    output logic        fv_o,
    output logic        lv_o,
    output logic        pay_valid_o,
    output logic [7:0]  pay_data_o,
    output logic        pay_last_o,
    output logic [5:0]  dt_o,
    output logic [15:0] wc_o,
    output logic        frame_start_o,
    output logic        frame_end_o,
    output logic        pkt_done_o,
    output logic        ecc_err_o,
    output logic        crc_err_o,
    output logic        len_err_o,
    output logic        trunc_err_o,
    output logic        frame_err_o,
    output logic [15:0] line_count_o
);

    state_e      state_q, state_d;
    logic [1:0]  hdr_idx_q, hdr_idx_d;
    logic [7:0]  di_q, di_d, wcl_q, wcl_d, wcm_q, wcm_d, crc_lo_q, crc_lo_d;
    logic [15:0] cnt_q, cnt_d;
    logic        fv_q, fv_d, lv_q, lv_d, pv_q, pv_d, pl_q, pl_d;
    logic [7:0]  pd_q, pd_d;
    logic [5:0]  dt_q, dt_d;
    logic [15:0] wc_q, wc_d, lc_q, lc_d;
    logic        fs_q, fs_d, fe_q, fe_d, done_q, done_d, ecc_q, ecc_d;
    logic        crce_q, crce_d, len_q, len_d, trunc_q, trunc_d, ferr_q, ferr_d;
    logic        crc_clear, crc_en;
    logic [15:0] crc_val;

    logic        sot, bv;
    logic [7:0]  bd;
    logic [15:0] hdr_wc;
    logic        ecc_ok, hdr_long, hdr_len_bad, hdr_vc_ok;

    assign sot         = byte_if.sot;
    assign bv          = byte_if.byte_valid;
    assign bd          = byte_if.byte_data;
    assign hdr_wc      = {wcm_q, wcl_q};
    assign ecc_ok      = (csi2_ecc({wcm_q, wcl_q, di_q}) == bd);
    assign hdr_long    = (di_q[5:0] >= DT_LONG_MIN);
    assign hdr_len_bad = (hdr_wc > MAX_WC);
    assign hdr_vc_ok   = (di_q[7:6] == ACCEPT_VC);

    csi2_crc16 u_crc (
        .hf_clk90     (hf_clk90),
        .reset_n_byte (reset_n_byte),
        .clear_i      (crc_clear),
        .en_i         (crc_en),
        .data_i       (bd),
        .crc_o        (crc_val)
    );

    // State register.
    always_ff @(posedge hf_clk90 or negedge reset_n_byte) begin
        if (!reset_n_byte) state_q <= IDLE;
        else               state_q <= state_d;
    end

    // Next state: sot always restarts the header, a dropped byte_valid aborts.
    always_comb begin
        state_d = state_q;
        if (bv && sot) begin
            state_d = HDR;
        end else if (state_q != IDLE && !bv) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                HDR: if (hdr_idx_q == 2'd3) begin
                    if (!ecc_ok || !hdr_long || hdr_len_bad) state_d = IDLE;
                    else if (!hdr_vc_ok)                     state_d = SKIP;
                    else if (hdr_wc == 16'd0)                state_d = CRC;
                    else                                     state_d = PAYLOAD;
                end
                PAYLOAD: if (cnt_q == 16'd1) state_d = CRC;
                CRC:     if (cnt_q == 16'd1) state_d = IDLE;
                SKIP:    if (cnt_q == 16'd1) state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // Output and datapath next values; cnt_q counts payload, then CRC bytes.
    always_comb begin
        hdr_idx_d = hdr_idx_q;
        di_d = di_q; wcl_d = wcl_q; wcm_d = wcm_q; crc_lo_d = crc_lo_q;
        cnt_d = cnt_q;
        fv_d = fv_q; dt_d = dt_q; wc_d = wc_q; lc_d = lc_q;
        lv_d = 1'b0; pv_d = 1'b0; pl_d = 1'b0; pd_d = 8'h00;
        fs_d = 1'b0; fe_d = 1'b0; done_d = 1'b0; ecc_d = 1'b0;
        crce_d = 1'b0; len_d = 1'b0; trunc_d = 1'b0; ferr_d = 1'b0;
        crc_clear = 1'b0; crc_en = 1'b0;
        if (bv && sot) begin
            trunc_d   = (state_q != IDLE);
            di_d      = bd;
            hdr_idx_d = 2'd1;
            crc_clear = 1'b1;
        end else if (state_q != IDLE && !bv) begin
            trunc_d = 1'b1;
        end else begin
            case (state_q)
                HDR: begin
                    hdr_idx_d = hdr_idx_q + 2'd1;
                    if (hdr_idx_q == 2'd1) wcl_d = bd;
                    if (hdr_idx_q == 2'd2) wcm_d = bd;
                    if (hdr_idx_q == 2'd3) begin
                        if (!ecc_ok) begin
                            ecc_d = 1'b1;
                        end else if (!hdr_long) begin
                            if (di_q[5:0] == DT_FS) begin
                                fs_d = 1'b1; ferr_d = fv_q; fv_d = 1'b1; lc_d = 16'd0;
                            end else if (di_q[5:0] == DT_FE) begin
                                fe_d = 1'b1; ferr_d = !fv_q; fv_d = 1'b0;
                            end
                        end else if (hdr_len_bad) begin
                            len_d = 1'b1;
                        end else if (!hdr_vc_ok) begin
                            cnt_d = hdr_wc + 16'd2;
                        end else begin
                            dt_d  = di_q[5:0];
                            wc_d  = hdr_wc;
                            cnt_d = (hdr_wc == 16'd0) ? 16'd2 : hdr_wc;
                        end
                    end
                end
                PAYLOAD: begin
                    pv_d = 1'b1; lv_d = 1'b1; pd_d = bd; crc_en = 1'b1;
                    pl_d  = (cnt_q == 16'd1);
                    cnt_d = (cnt_q == 16'd1) ? 16'd2 : cnt_q - 16'd1;
                end
                CRC: begin
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd2) begin
                        crc_lo_d = bd;
                    end else begin
                        done_d = 1'b1;
                        crce_d = ({bd, crc_lo_q} != crc_val);
                        if (!crce_d && dt_q == EXPECT_DT) lc_d = lc_q + 16'd1;
                    end
                end
                SKIP:    cnt_d = cnt_q - 16'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge hf_clk90 or negedge reset_n_byte) begin
        if (!reset_n_byte) begin
            hdr_idx_q <= 2'd0; di_q <= 8'h00; wcl_q <= 8'h00; wcm_q <= 8'h00;
            crc_lo_q <= 8'h00; cnt_q <= 16'd0;
            fv_q <= 1'b0; lv_q <= 1'b0; pv_q <= 1'b0; pl_q <= 1'b0; pd_q <= 8'h00;
            dt_q <= 6'h00; wc_q <= 16'd0; lc_q <= 16'd0;
            fs_q <= 1'b0; fe_q <= 1'b0; done_q <= 1'b0; ecc_q <= 1'b0;
            crce_q <= 1'b0; len_q <= 1'b0; trunc_q <= 1'b0; ferr_q <= 1'b0;
        end else begin
            hdr_idx_q <= hdr_idx_d; di_q <= di_d; wcl_q <= wcl_d; wcm_q <= wcm_d;
            crc_lo_q <= crc_lo_d; cnt_q <= cnt_d;
            fv_q <= fv_d; lv_q <= lv_d; pv_q <= pv_d; pl_q <= pl_d; pd_q <= pd_d;
            dt_q <= dt_d; wc_q <= wc_d; lc_q <= lc_d;
            fs_q <= fs_d; fe_q <= fe_d; done_q <= done_d; ecc_q <= ecc_d;
            crce_q <= crce_d; len_q <= len_d; trunc_q <= trunc_d; ferr_q <= ferr_d;
        end
    end

    assign fv_o          = fv_q;
    assign lv_o          = lv_q;
    assign pay_valid_o   = pv_q;
    assign pay_data_o    = pd_q;
    assign pay_last_o    = pl_q;
    assign dt_o          = dt_q;
    assign wc_o          = wc_q;
    assign frame_start_o = fs_q;
    assign frame_end_o   = fe_q;
    assign pkt_done_o    = done_q;
    assign ecc_err_o     = ecc_q;
    assign crc_err_o     = crce_q;
    assign len_err_o     = len_q;
    assign trunc_err_o   = trunc_q;
    assign frame_err_o   = ferr_q;
    assign line_count_o  = lc_q;

endmodule

// File: tb/tb_csi2_rx_packet_parser.sv
// Purpose: directed, table-driven check of the CSI-2 packet parser.
// Latency: each vector's expected outputs are sampled 1 ns after the edge that takes its byte.
// Backpressure: n/a (stream source only).
module tb_csi2_rx_packet_parser;

    logic hf_clk90 = 1'b0;
    logic reset_n_byte;
    always #5 hf_clk90 = ~hf_clk90;

    csi2_rx_packet_parser_if bus ();

    logic        fv_o, lv_o, pay_valid_o, pay_last_o;
    logic [7:0]  pay_data_o;
    logic [5:0]  dt_o;
    logic [15:0] wc_o, line_count_o;
    logic        frame_start_o, frame_end_o, pkt_done_o;
    logic        ecc_err_o, crc_err_o, len_err_o, trunc_err_o, frame_err_o;

    csi2_rx_packet_parser #(
        .MAX_WC    (16'd320),
        .ACCEPT_VC (2'b00),
        .EXPECT_DT (6'h2B)
    ) dut (
        .hf_clk90      (hf_clk90),
        .reset_n_byte  (reset_n_byte),
        .byte_if       (bus),
        .fv_o          (fv_o),
        .lv_o          (lv_o),
        .pay_valid_o   (pay_valid_o),
        .pay_data_o    (pay_data_o),
        .pay_last_o    (pay_last_o),
        .dt_o          (dt_o),
        .wc_o          (wc_o),
        .frame_start_o (frame_start_o),
        .frame_end_o   (frame_end_o),
        .pkt_done_o    (pkt_done_o),
        .ecc_err_o     (ecc_err_o),
        .crc_err_o     (crc_err_o),
        .len_err_o     (len_err_o),
        .trunc_err_o   (trunc_err_o),
        .frame_err_o   (frame_err_o),
        .line_count_o  (line_count_o)
    );

    // Pulse vector order: {fs, fe, done, ecc, crc, len, trunc, ferr}.
    localparam logic [7:0] P_NONE = 8'h00, P_FS = 8'h80, P_FE = 8'h40, P_DONE = 8'h20,
                           P_ECC = 8'h10, P_CRC = 8'h08, P_LEN = 8'h04,
                           P_TRUNC = 8'h02, P_FERR = 8'h01;

    typedef struct packed {
        logic       fv;
        logic       lv;
        logic       pv;
        logic       pl;
        logic [7:0] pd;
        logic [7:0] pls;
    } obs_t;

    typedef struct {
        logic       sot;
        logic       vld;
        logic [7:0] dat;
        obs_t       exp;
    } vec_t;

    vec_t vq[$];
    logic cur_fv = 1'b0;
    int   tests = 0;
    int   fails = 0;

    // Reference payload whose CRC-16 is 0xE569 (sent as 69 E5).
    logic [7:0] pay [24] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h1E, 8'hF0, 8'h1E, 8'hC7,
                             8'h4F, 8'h82, 8'h78, 8'hC5, 8'h82, 8'hE0, 8'h8C, 8'h70,
                             8'hD2, 8'h3C, 8'h78, 8'hE9, 8'hFF, 8'h00, 8'h00, 8'h01};

    function automatic obs_t sample();
        obs_t o;
        o.fv  = fv_o;
        o.lv  = lv_o;
        o.pv  = pay_valid_o;
        o.pl  = pay_last_o;
        o.pd  = pay_data_o;
        o.pls = {frame_start_o, frame_end_o, pkt_done_o, ecc_err_o,
                 crc_err_o, len_err_o, trunc_err_o, frame_err_o};
        return o;
    endfunction

    task automatic push(input logic s, input logic v, input logic [7:0] d,
                        input logic lv, input logic pv, input logic pl,
                        input logic [7:0] pd, input logic [7:0] pls);
        vec_t r;
        r.sot = s; r.vld = v; r.dat = d;
        r.exp.fv = cur_fv; r.exp.lv = lv; r.exp.pv = pv; r.exp.pl = pl;
        r.exp.pd = pd; r.exp.pls = pls;
        vq.push_back(r);
    endtask

    task automatic idle_byte(input logic s, input logic v, input logic [7:0] d,
                             input logic [7:0] pls);
        push(s, v, d, 1'b0, 1'b0, 1'b0, 8'h00, pls);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) idle_byte(1'b0, 1'b0, 8'h00, P_NONE);
    endtask

    task automatic hdr(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic fv_after, input logic [7:0] pls);
        idle_byte(1'b1, 1'b1, b0, P_NONE);
        idle_byte(1'b0, 1'b1, b1, P_NONE);
        idle_byte(1'b0, 1'b1, b2, P_NONE);
        cur_fv = fv_after;
        idle_byte(1'b0, 1'b1, b3, pls);
    endtask

    task automatic payload(input int n, input logic full);
        for (int i = 0; i < n; i++)
            push(1'b0, 1'b1, pay[i], 1'b1, 1'b1, full && (i == n - 1), pay[i], P_NONE);
    endtask

    task automatic long_pkt(input logic [7:0] crc_lo, input logic [7:0] pls);
        hdr(8'h2B, 8'h18, 8'h00, 8'h14, cur_fv, P_NONE);
        payload(24, 1'b1);
        idle_byte(1'b0, 1'b1, crc_lo, P_NONE);
        idle_byte(1'b0, 1'b1, 8'hE5, pls);
        gap(1);
    endtask

    task automatic run_table(input string tag);
        obs_t act;
        for (int i = 0; i < vq.size(); i++) begin
            bus.sot        = vq[i].sot;
            bus.byte_valid = vq[i].vld;
            bus.byte_data  = vq[i].dat;
            @(posedge hf_clk90);
            #1;
            act = sample();
            tests++;
            if (act !== vq[i].exp) begin
                fails++;
                $display("FAIL %s[%0d] {fv,lv,pv,pl,pd,pulses} got %h expected %h",
                         tag, i, act, vq[i].exp);
            end
        end
        vq.delete();
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        obs_t act;
        reset_n_byte   = 1'b0;
        bus.sot        = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (3) @(posedge hf_clk90);
        #1;
        act = sample();
        chk("reset_outputs", 16'(act), 16'h0000);
        chk("reset_dt", {10'd0, dt_o}, 16'h0000);
        chk("reset_wc", wc_o, 16'h0000);
        chk("reset_line_count", line_count_o, 16'h0000);
        reset_n_byte = 1'b1;

        // FS, FE (ECC of DI=01 is 07), FS again.
        gap(2);
        hdr(8'h00, 8'h00, 8'h00, 8'h00, 1'b1, P_FS); gap(1);
        hdr(8'h01, 8'h00, 8'h00, 8'h07, 1'b0, P_FE); gap(1);
        hdr(8'h00, 8'h00, 8'h00, 8'h00, 1'b1, P_FS); gap(1);
        run_table("frame");
        chk("lc_after_fs", line_count_o, 16'd0);

        long_pkt(8'h69, P_DONE);
        run_table("long_ok");
        chk("dt_long", {10'd0, dt_o}, 16'h002B);
        chk("wc_long", wc_o, 16'd24);
        chk("lc_long_ok", line_count_o, 16'd1);

        long_pkt(8'h68, P_DONE | P_CRC);
        run_table("long_badcrc");
        chk("lc_badcrc", line_count_o, 16'd1);

        // Bad ECC, trailing bytes ignored, FS while in frame, FE, FE outside frame, FS.
        hdr(8'h2B, 8'h18, 8'h00, 8'h15, cur_fv, P_ECC);
        for (int i = 0; i < 4; i++) idle_byte(1'b0, 1'b1, pay[i], P_NONE);
        gap(1);
        hdr(8'h00, 8'h00, 8'h00, 8'h00, 1'b1, P_FS | P_FERR); gap(1);
        run_table("ecc_err");
        chk("lc_after_fs2", line_count_o, 16'd0);
        hdr(8'h01, 8'h00, 8'h00, 8'h07, 1'b0, P_FE); gap(1);
        hdr(8'h01, 8'h00, 8'h00, 8'h07, 1'b0, P_FE | P_FERR); gap(1);
        hdr(8'h00, 8'h00, 8'h00, 8'h00, 1'b1, P_FS); gap(1);
        run_table("frame_err");

        // wc = 321 with a correct ECC.
        hdr(8'h2B, 8'h41, 8'h01, 8'h16, cur_fv, P_LEN);
        for (int i = 0; i < 3; i++) idle_byte(1'b0, 1'b1, pay[i], P_NONE);
        gap(1);
        run_table("len_err");
        chk("wc_after_len_err", wc_o, 16'd24);

        // byte_valid dropped after the 10th payload byte.
        hdr(8'h2B, 8'h18, 8'h00, 8'h14, cur_fv, P_NONE);
        payload(10, 1'b0);
        idle_byte(1'b0, 1'b0, 8'h00, P_TRUNC);
        for (int i = 0; i < 2; i++) idle_byte(1'b0, 1'b1, pay[i], P_NONE);
        gap(1);
        run_table("trunc");
        chk("lc_after_trunc", line_count_o, 16'd0);

        // Close the frame, then sot mid-payload carrying a valid FS header.
        hdr(8'h01, 8'h00, 8'h00, 8'h07, 1'b0, P_FE); gap(1);
        hdr(8'h2B, 8'h18, 8'h00, 8'h14, cur_fv, P_NONE);
        payload(5, 1'b0);
        idle_byte(1'b1, 1'b1, 8'h00, P_TRUNC);
        idle_byte(1'b0, 1'b1, 8'h00, P_NONE);
        idle_byte(1'b0, 1'b1, 8'h00, P_NONE);
        cur_fv = 1'b1;
        idle_byte(1'b0, 1'b1, 8'h00, P_FS);
        gap(1);
        run_table("sot_mid");

        // VC 1 long packet (wc = 2) is skipped; an FE right behind it parses cleanly.
        hdr(8'h6B, 8'h02, 8'h00, 8'h1D, cur_fv, P_NONE);
        idle_byte(1'b0, 1'b1, 8'hAA, P_NONE);
        idle_byte(1'b0, 1'b1, 8'h55, P_NONE);
        idle_byte(1'b0, 1'b1, 8'h12, P_NONE);
        idle_byte(1'b0, 1'b1, 8'h34, P_NONE);
        hdr(8'h01, 8'h00, 8'h00, 8'h07, 1'b0, P_FE); gap(1);
        run_table("skip_vc");
        chk("dt_after_skip", {10'd0, dt_o}, 16'h002B);
        chk("wc_after_skip", wc_o, 16'd24);

        // wc = 0: straight to CRC (empty-payload CRC is FFFF), lv never rises.
        hdr(8'h2B, 8'h00, 8'h00, 8'h17, cur_fv, P_NONE);
        idle_byte(1'b0, 1'b1, 8'hFF, P_NONE);
        idle_byte(1'b0, 1'b1, 8'hFF, P_DONE);
        gap(1);
        run_table("wc_zero");
        chk("wc_zero_wc", wc_o, 16'd0);
        chk("wc_zero_lc", line_count_o, 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
